pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
- REQ-001: Parameter WIDTH, default 16: operand and sum width in bits, at least 2.
- REQ-002: Parameter SEG, default 4: carry-chain segment width per pipeline stage; WIDTH SHALL be a multiple of SEG.
- REQ-003: Parameter SAT, default 0: 0 = wrap-around result, 1 = unsigned saturation.
- REQ-004: Derived constant STAGES = WIDTH/SEG SHALL set the pipeline depth.
- REQ-005: clk  input  1  single clock; all state updates on the rising edge.
- REQ-006: rst  input  1  reset, asynchronous and active-high.
- REQ-007: in_valid  input  1  operand beat offered.
- REQ-008: in_ready  output  1  block accepts a beat this cycle.
- REQ-009: a  input  WIDTH  operand A.
- REQ-010: b  input  WIDTH  operand B.
- REQ-011: cin  input  1  carry into bit 0.
- REQ-012: out_valid  output  1  result beat present.
- REQ-013: out_ready  input  1  downstream accepts the result.
- REQ-014: sum  output  WIDTH  result, after optional saturation.
- REQ-015: cout  output  1  carry out of bit WIDTH-1, before saturation.
- REQ-016: ovf  output  1  two's-complement signed overflow of a+b+cin.
- REQ-017: busy  output  1  at least one beat is in flight in any stage.

Function
- REQ-018: Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] of a, b and the registered carry from stage k-1 (cin for k=0).
- REQ-019: Each stage SHALL register its partial sum, its carry and a valid bit; not-yet-consumed operand slices SHALL be delayed alongside, so no combinational path spans more than one SEG-bit carry chain.
- REQ-020: Latency SHALL be exactly STAGES cycles from acceptance (in_valid && in_ready) to out_valid, with no back-pressure.
- REQ-021: Throughput SHALL be one beat per cycle while out_ready is held high.
- REQ-022: A stall condition SHALL be defined as out_valid && !out_ready.
- REQ-023: During a stall, every stage register SHALL hold its value, and in_ready SHALL be 0.
- REQ-024: Outside a stall, in_ready SHALL be 1. This is a combinational function of out_valid and out_ready.
- REQ-025: Empty stages SHALL advance even when downstream stages are empty (bubbles collapse only at the output; no internal compaction is required).
- REQ-026: sum, cout and ovf SHALL be held stable while out_valid is 1 and out_ready is 0.
- REQ-027: ovf SHALL equal (a[W-1]==b[W-1]) && (raw_sum[W-1]!=a[W-1]) for the accepted beat.
- REQ-028: When SAT=1 and cout=1, sum SHALL be all ones. Otherwise sum SHALL equal (a+b+cin) mod 2^WIDTH.
- REQ-029: Beats SHALL exit in acceptance order; none SHALL be dropped or duplicated.
- REQ-030: busy SHALL be the OR of all stage valid bits.
- REQ-031: Data registers of invalid stages are don't-care. Outputs are only meaningful when out_valid=1.

Reset
- REQ-032: While rst=1, all stage valid bits SHALL be cleared immediately, without waiting for a clock edge.
- REQ-033: While rst=1, out_valid=0, busy=0, sum=0, cout=0 and ovf=0.
- REQ-034: in_ready SHALL be 1 during and after reset.
- REQ-035: A reset asserted mid-operation SHALL discard all in-flight beats.
- REQ-036: The first beat accepted after rst deasserts SHALL appear after exactly STAGES cycles.

Verification (WIDTH=16, SEG=4, SAT=0 unless stated)
- REQ-037: Single beat a=0x00FF, b=0x0001, cin=0 -> out_valid exactly 4 cycles later; sum=0x0100, cout=0, ovf=0.
- REQ-038: Carry through all stages, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Same stimulus with SAT=1 -> sum=0xFFFF, cout=1.
- REQ-039: Signed overflow, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
- REQ-040: Back-to-back stream of 8 beats (a=i, b=0x10*i) with out_ready=1 -> 8 consecutive out_valid cycles, sums equal to 0x11*i, in order.
- REQ-041: Stall: hold out_ready=0 for 5 cycles while a stream is in flight -> in_ready=0, sum stable, no loss. Then release -> remaining beats exit in order, one per cycle.
- REQ-042: Assert rst asynchronously with 3 beats in flight -> out_valid=0 and busy=0 before the next clock edge; no stale beat appears after release.

Source files
------------

// File: rtl/pipelined_adder.sv
// Ripple-carry adder cut into WIDTH/SEG registered segments with valid/ready flow control.
// Every stage holds together on an output stall, so no internal skid buffering is needed.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int STAGES = WIDTH / SEG;

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] c_all;
  logic [WIDTH-1:0]  a_all [STAGES];
  logic [WIDTH-1:0]  b_all [STAGES];
  logic [WIDTH-1:0]  s_all [STAGES];
  logic              advance;

  // The whole pipe moves as one; a stall freezes every stage at once.
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;
  assign out_valid = v_all[STAGES-1];
  assign busy      = |v_all;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_next;
    logic             c_in, v_in;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic             c_r, v_r;

    if (k == 0) begin : g_first
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign c_in = cin;
      assign v_in = in_valid;
    end else begin : g_next
      assign a_in = a_all[k-1];
      assign b_in = b_all[k-1];
      assign s_in = s_all[k-1];
      assign c_in = c_all[k-1];
      assign v_in = v_all[k-1];
    end

    assign seg_sum = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    always_comb begin
      s_next                = s_in;
      s_next[k*SEG +: SEG]  = seg_sum[SEG-1:0];
    end

    // NOTE: data registers are reset along with valid so sum/cout/ovf read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
      end else if (advance) begin
        v_r <= v_in;
        c_r <= seg_sum[SEG];
        a_r <= a_in;
        b_r <= b_in;
        s_r <= s_next;
      end
    end

    assign v_all[k] = v_r;
    assign c_all[k] = c_r;
    assign a_all[k] = a_r;
    assign b_all[k] = b_r;
    assign s_all[k] = s_r;
  end

  logic [WIDTH-1:0] raw_sum;
  logic             a_msb, b_msb;
  logic             unused_ops;

  assign raw_sum    = s_all[STAGES-1];
  assign a_msb      = a_all[STAGES-1][WIDTH-1];
  assign b_msb      = b_all[STAGES-1][WIDTH-1];
  // Only the operand sign bits matter past the last stage; the rest is left for synthesis to prune.
  assign unused_ops = ^{a_all[STAGES-1][WIDTH-2:0], b_all[STAGES-1][WIDTH-2:0]};

  assign cout = c_all[STAGES-1];
  assign ovf  = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
  assign sum  = ((SAT != 0) && cout) ? '1 : raw_sum;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (16-bit, 4-bit segments); a SAT=1 copy shares the stimulus.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;

  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum;
  logic        in_ready_s, out_valid_s, cout_s, ovf_s, busy_s;
  logic [15:0] sum_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .SEG(4), .SAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  pipelined_adder #(.WIDTH(16), .SEG(4), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .cout(cout_s), .ovf(ovf_s), .busy(busy_s)
  );

  // Offers one beat, then waits (bounded) for it to appear; lat counts rising edges from acceptance.
  task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output int lat, output logic [15:0] s, output logic co,
                         output logic ov, output logic [15:0] ss, output logic sco);
    @(negedge clk);
    out_ready = 1'b1;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s = sum; co = cout; ov = ovf; ss = sum_s; sco = cout_s;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sum !== 16'h0000)   begin bad++; $display("FAIL reset_sum got=%h want=0000", sum); end
    total++; if (cout !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags got cout=%b ovf=%b want 0 0", cout, ovf); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    int lat; logic [15:0] s, ss; logic co, ov, sco;
    run_one(16'h00FF, 16'h0001, 1'b0, lat, s, co, ov, ss, sco);
    total++; if (lat !== 4)       begin bad++; $display("FAIL single_latency got=%0d want=4", lat); end
    total++; if (s !== 16'h0100)  begin bad++; $display("FAIL single_sum got=%h want=0100", s); end
    total++; if (co !== 1'b0)     begin bad++; $display("FAIL single_cout got=%b want=0", co); end
    total++; if (ov !== 1'b0)     begin bad++; $display("FAIL single_ovf got=%b want=0", ov); end
  endtask

  task automatic test_carry_chain();
    int lat; logic [15:0] s, ss; logic co, ov, sco;
    run_one(16'hFFFF, 16'h0000, 1'b1, lat, s, co, ov, ss, sco);
    total++; if (lat !== 4)       begin bad++; $display("FAIL carry_latency got=%0d want=4", lat); end
    total++; if (s !== 16'h0000)  begin bad++; $display("FAIL carry_sum got=%h want=0000", s); end
    total++; if (co !== 1'b1)     begin bad++; $display("FAIL carry_cout got=%b want=1", co); end
    total++; if (ov !== 1'b0)     begin bad++; $display("FAIL carry_ovf got=%b want=0", ov); end
    total++; if (ss !== 16'hFFFF) begin bad++; $display("FAIL carry_sat_sum got=%h want=ffff", ss); end
    total++; if (sco !== 1'b1)    begin bad++; $display("FAIL carry_sat_cout got=%b want=1", sco); end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] s, ss; logic co, ov, sco;
    run_one(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov, ss, sco);
    total++; if (s !== 16'h8000)  begin bad++; $display("FAIL ovf_pos_sum got=%h want=8000", s); end
    total++; if (ov !== 1'b1)     begin bad++; $display("FAIL ovf_pos_ovf got=%b want=1", ov); end
    total++; if (co !== 1'b0)     begin bad++; $display("FAIL ovf_pos_cout got=%b want=0", co); end
    total++; if (ss !== 16'h8000) begin bad++; $display("FAIL ovf_pos_sat_sum got=%h want=8000", ss); end
    run_one(16'h8000, 16'h8000, 1'b0, lat, s, co, ov, ss, sco);
    total++; if (s !== 16'h0000)  begin bad++; $display("FAIL ovf_neg_sum got=%h want=0000", s); end
    total++; if (ov !== 1'b1)     begin bad++; $display("FAIL ovf_neg_ovf got=%b want=1", ov); end
    total++; if (co !== 1'b1)     begin bad++; $display("FAIL ovf_neg_cout got=%b want=1", co); end
    total++; if (ss !== 16'hFFFF) begin bad++; $display("FAIL ovf_neg_sat_sum got=%h want=ffff", ss); end
  endtask

  task automatic test_back_to_back();
    int          cyc[$];
    logic [15:0] got[$];
    int          ready_drops = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        cyc.push_back(c);
        got.push_back(sum);
      end
      if (!in_ready) ready_drops++;
      if (c < 8) begin
        a = 16'(c); b = 16'(16'h10 * c); cin = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
    end
    total++; if (got.size() !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got.size()); end
    total++; if (ready_drops !== 0) begin bad++; $display("FAIL b2b_in_ready low_cycles=%0d want=0", ready_drops); end
    if (got.size() == 8) begin
      total++; if (cyc[0] !== 4) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=4", cyc[0]); end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got[i] !== 16'(16'h11 * i)) begin
          bad++; $display("FAIL b2b_sum[%0d] got=%h want=%h", i, got[i], 16'(16'h11 * i));
        end
        if (i > 0) begin
          total++;
          if (cyc[i] !== cyc[i-1] + 1) begin
            bad++; $display("FAIL b2b_gap[%0d] got_cycle=%0d want=%0d", i, cyc[i], cyc[i-1] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int          cyc[$];
    logic [15:0] got[$];
    int          nxt = 0;
    int          stalls = 0;
    logic [15:0] held = '0;
    logic        have_held = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (out_valid && out_ready) begin
        cyc.push_back(c);
        got.push_back(sum);
      end
      if (out_valid && !out_ready) begin
        stalls++;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cycle=%0d got=%b want=0", c, in_ready); end
        if (have_held) begin
          total++; if (sum !== held) begin bad++; $display("FAIL stall_sum_stable cycle=%0d got=%h want=%h", c, sum, held); end
        end
        held = sum;
        have_held = 1'b1;
      end
      if (nxt < 8) begin
        a = 16'(16'h1000 + nxt); b = 16'(nxt); cin = 1'b0; in_valid = 1'b1;
        if (in_ready) nxt++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (stalls !== 5) begin bad++; $display("FAIL stall_cycles got=%0d want=5", stalls); end
    total++; if (got.size() !== 8) begin bad++; $display("FAIL stall_count got=%0d want=8", got.size()); end
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got[i] !== 16'(16'h1000 + 2 * i)) begin
          bad++; $display("FAIL stall_sum[%0d] got=%h want=%h", i, got[i], 16'(16'h1000 + 2 * i));
        end
      end
      for (int i = 3; i < 8; i++) begin
        total++;
        if (cyc[i] !== cyc[i-1] + 1) begin
          bad++; $display("FAIL stall_release_gap[%0d] got_cycle=%0d want=%0d", i, cyc[i], cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    int stale = 0;
    int lat; logic [15:0] s, ss; logic co, ov, sco;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      a = 16'(16'h0100 * (c + 1)); b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale_beats got=%0d want=0", stale); end
    run_one(16'h1234, 16'h1111, 1'b1, lat, s, co, ov, ss, sco);
    total++; if (lat !== 4)      begin bad++; $display("FAIL mid_first_latency got=%0d want=4", lat); end
    total++; if (s !== 16'h2346) begin bad++; $display("FAIL mid_first_sum got=%h want=2346", s); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_mid_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
